// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button conditioner.
//   NUM_BUTTONS          : number of board push-buttons handled
//   DEF_DEBOUNCE_CYCLES  : default stable-sample count (10 ms at 50 MHz)
//   DEF_CNT_W            : default debounce counter width
//   ST_IDLE / ST_PRESENT : output FSM state encoding
//   hi_index / onehot    : priority pick and request encoding helpers
package button_conditioner_pkg;

  localparam int NUM_BUTTONS         = 4;
  localparam int SEL_W               = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_CNT_W           = 19;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  // Highest set bit wins: bit 3 matches the CPU's highest vector.
  function automatic logic [SEL_W-1:0] hi_index(input logic [NUM_BUTTONS-1:0] v);
    hi_index = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (v[i]) hi_index = SEL_W'(i);
    end
  endfunction

  function automatic logic [NUM_BUTTONS-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button conditioner bus.
//   key_n           : raw active-low push-buttons (asynchronous)
//   int_ack         : one-cycle acceptance pulse from the CPU side
//   buttons_pressed : one-hot interrupt request
//   btn_level       : debounced level per button, 1 = pressed
// Handshake: buttons_pressed acts as a valid that stays constant until the
// cycle int_ack is high (the ready/accept); the request drops on that same
// edge and is low for at least one cycle before the next one. int_ack while
// no request is shown has no effect.
interface button_conditioner_if;
  import button_conditioner_pkg::*;

  logic [NUM_BUTTONS-1:0] key_n;
  logic                   int_ack;
  logic [NUM_BUTTONS-1:0] buttons_pressed;
  logic [NUM_BUTTONS-1:0] btn_level;

  modport master (
    output key_n,
    output int_ack,
    input  buttons_pressed,
    input  btn_level
  );

  modport slave (
    input  key_n,
    input  int_ack,
    output buttons_pressed,
    output btn_level
  );
endinterface

// File: rtl/button_debounce.sv
// Single-button debouncer.
//   clk, rst    : clock, asynchronous active-high reset
//   key_n       : raw active-low button
//   stable_n    : debounced active-low level (1 = released)
//   press_pulse : one-cycle pulse the cycle after a released->pressed change
module button_debounce
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic stable_n,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_n;
  logic             sync2_n;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_n     <= 1'b1;
      sync2_n     <= 1'b1;
      stable_n    <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1_n     <= key_n;
      sync2_n     <= sync1_n;
      press_pulse <= 1'b0;
      if (sync2_n == stable_n) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // DEBOUNCE_CYCLES consecutive differing samples: accept the change.
        stable_n    <= sync2_n;
        cnt         <= '0;
        press_pulse <= ~sync2_n;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces four push-buttons and turns presses into one-hot interrupt
// requests, presented one at a time in priority order (bit 3 highest).
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : button_conditioner_if.slave (key_n, int_ack in;
//               buttons_pressed, btn_level out)
//   dbg_state : current output FSM state (ST_IDLE / ST_PRESENT)
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  button_conditioner_if.slave   bus,
  output logic [0:0]            dbg_state
);

  logic [NUM_BUTTONS-1:0] stable_n;
  logic [NUM_BUTTONS-1:0] press_pulse;
  logic [NUM_BUTTONS-1:0] pending;
  logic [NUM_BUTTONS-1:0] pend_next;
  logic [NUM_BUTTONS-1:0] bp_q;
  logic [SEL_W-1:0]       sel;
  logic [0:0]             state;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_deb
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk         (clk),
      .rst         (rst),
      .key_n       (bus.key_n[i]),
      .stable_n    (stable_n[i]),
      .press_pulse (press_pulse[i])
    );
  end

  // New presses always set; an accepted request clears its own bit unless a
  // fresh press of that same button lands on the accept edge.
  always_comb begin
    pend_next = pending | press_pulse;
    if (state == ST_PRESENT && bus.int_ack) begin
      pend_next[sel] = press_pulse[sel];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel     <= '0;
      pending <= '0;
      bp_q    <= '0;
    end else begin
      pending <= pend_next;
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            sel   <= hi_index(pending);
            bp_q  <= onehot(hi_index(pending));
            state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // Going back through IDLE guarantees a zero cycle between requests.
          if (bus.int_ack) begin
            bp_q  <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.buttons_pressed = bp_q;
  assign bus.btn_level       = ~stable_n;
  assign dbg_state           = state;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES = 4.
module tb_button_conditioner;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic       int_ack = 1'b0;
  logic [0:0] dbg_state;
  bit         chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  button_conditioner_if bus ();
  assign bus.key_n   = key_n;
  assign bus.int_ack = int_ack;

  button_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Pressed-polarity view: a button's debounced level flips once its last N
  // synchronized samples (raw samples delayed two edges) all disagree with it.
  // Requests: a press becomes pending one edge after the flip; while nothing is
  // shown the highest pending button is shown; an ack drops the request.
  bit         hist[4][$];
  bit         win[4][$];
  logic [3:0] m_level, m_pending, m_bp, m_press_d;

  function automatic logic [3:0] highest(input logic [3:0] v);
    highest = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) begin
        highest = 4'b0001 << i;
        break;
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hist[i].delete();
      hist[i].push_back(1'b0);
      hist[i].push_back(1'b0);
      win[i].delete();
    end
    m_level = '0; m_pending = '0; m_bp = '0; m_press_d = '0;
  endtask

  task automatic model_step();
    logic [3:0] press_now, np, nbp;
    bit s, all_diff;
    press_now = '0;
    for (int i = 0; i < 4; i++) begin
      hist[i].push_back(~key_n[i]);
      s = hist[i].pop_front();
      win[i].push_back(s);
      if (win[i].size() > N) void'(win[i].pop_front());
      all_diff = (win[i].size() == N);
      foreach (win[i][k]) if (win[i][k] == m_level[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[i]   = s;
        press_now[i] = s;
      end
    end
    np  = m_pending | m_press_d;
    nbp = m_bp;
    if (m_bp != 0) begin
      if (int_ack) begin
        np  = (np & ~m_bp) | (m_press_d & m_bp);
        nbp = '0;
      end
    end else if (m_pending != 0) begin
      nbp = highest(m_pending);
    end
    m_pending = np;
    m_bp      = nbp;
    m_press_d = press_now;
  endtask

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (bus.buttons_pressed !== m_bp) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL bp t=%0t got=%b exp=%b", $time, bus.buttons_pressed, m_bp);
      end
      n_cmp++;
      if (bus.btn_level !== m_level) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL level t=%0t got=%b exp=%b", $time, bus.btn_level, m_level);
      end
      n_cmp++;
      if (dbg_state !== (m_bp != 0 ? 1'b1 : 1'b0)) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL state t=%0t got=%b exp_present=%b", $time, dbg_state, (m_bp != 0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic lit(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  task automatic ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int rem[4];

  initial begin
    steps(2);
    lit("reset_bp", bus.buttons_pressed, 4'b0000);
    lit("reset_level", bus.btn_level, 4'b0000);
    lit("reset_state", {3'b000, dbg_state}, 4'b0000);
    rst = 1'b0;
    chk_en = 1'b1;
    steps(3);

    // int_ack in IDLE is ignored
    ack();
    lit("idle_ack_bp", bus.buttons_pressed, 4'b0000);
    lit("idle_ack_state", {3'b000, dbg_state}, 4'b0000);
    steps(2);

    // button 0 press: request from edge 8, held until ack
    key_n = 4'b1110;
    steps(7);
    lit("b0_edge7", bus.buttons_pressed, 4'b0000);
    step();
    lit("b0_edge8", bus.buttons_pressed, 4'b0001);
    lit("b0_level", bus.btn_level, 4'b0001);
    steps(5);
    lit("b0_held", bus.buttons_pressed, 4'b0001);
    ack();
    lit("b0_ack", bus.buttons_pressed, 4'b0000);
    key_n = 4'hF;
    steps(12);
    lit("b0_release", bus.buttons_pressed, 4'b0000);

    // glitch of 3 samples on button 2 is rejected
    key_n = 4'b1011;
    steps(3);
    key_n = 4'hF;
    steps(12);
    lit("glitch_level", bus.btn_level, 4'b0000);
    lit("glitch_bp", bus.buttons_pressed, 4'b0000);

    // buttons 1 and 3 together: 3 first, zero cycle, then 1
    key_n = 4'b0101;
    steps(8);
    lit("dual_first", bus.buttons_pressed, 4'b1000);
    ack();
    lit("dual_gap", bus.buttons_pressed, 4'b0000);
    step();
    lit("dual_second", bus.buttons_pressed, 4'b0010);
    ack();
    key_n = 4'hF;
    steps(12);

    // button 3 re-press whose pending set lands on the ack edge
    key_n = 4'b0111;
    steps(8);
    lit("rep_first", bus.buttons_pressed, 4'b1000);
    key_n = 4'hF;
    steps(8);
    key_n = 4'b0111;
    steps(6);
    ack();
    lit("rep_gap", bus.buttons_pressed, 4'b0000);
    step();
    lit("rep_again", bus.buttons_pressed, 4'b1000);
    ack();
    key_n = 4'hF;
    steps(12);

    // reset mid-PRESENT drops everything
    key_n = 4'b1010;
    steps(8);
    lit("rst_pre", bus.buttons_pressed, 4'b0100);
    #1 rst = 1'b1;
    #1;
    lit("rst_bp", bus.buttons_pressed, 4'b0000);
    lit("rst_level", bus.btn_level, 4'b0000);
    key_n = 4'hF;
    steps(2);
    rst = 1'b0;
    steps(20);
    lit("rst_after", bus.buttons_pressed, 4'b0000);

    // button held through reset release is a fresh press
    key_n = 4'b1101;
    steps(10);
    ack();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(7);
    lit("held_edge7", bus.buttons_pressed, 4'b0000);
    step();
    lit("held_edge8", bus.buttons_pressed, 4'b0010);
    ack();
    key_n = 4'hF;
    steps(12);

    // randomized phase
    for (int i = 0; i < 4; i++) rem[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          if ($urandom_range(0, 1) == 1) key_n[i] = ~key_n[i];
          rem[i] = $urandom_range(1, 12);
        end else begin
          rem[i]--;
        end
      end
      int_ack = ($urandom_range(0, 3) == 0);
      step();
    end
    int_ack = 1'b0;
    key_n = 4'hF;
    steps(15);
    repeat (8) begin
      ack();
      step();
    end
    steps(4);
    lit("final_bp", bus.buttons_pressed, 4'b0000);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
